// File: rtl/vga_draw_pkg.sv
// vga_draw_pkg: shared types and constants for the sprite draw path
package vga_draw_pkg;
  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int SPRITE_SIDE = 4;
  localparam int PIX_CNT_W = 4;
  function automatic int onehot_idx(input logic [7:0] v);
    onehot_idx = 0;
    for (int i = 0; i < 8; i++) if (v[i]) onehot_idx = i;
  endfunction
endpackage

// File: rtl/rr_arbiter_n.sv
// rr_arbiter_n: combinational round-robin pick, searching upward from last_grant+1
//   req        requests, one bit per requester
//   last_grant index of the most recently served requester
//   pick       one-hot winner (zero when no request)
//   valid      any request pending
module rr_arbiter_n #(
  parameter int N_REQ = 3,
  localparam int LG = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [LG-1:0]    last_grant,
  output logic [N_REQ-1:0] pick,
  output logic             valid
);
  logic [LG-1:0] j;
  always_comb begin
    pick = '0;
    j = '0;
    // descending walk so the nearest requester after last_grant is assigned last and wins
    for (int i = N_REQ; i >= 1; i--) begin
      j = LG'((int'(last_grant) + i) % N_REQ);
      if (req[j]) pick = N_REQ'(1) << j;
    end
  end
  assign valid = |req;
endmodule

// File: rtl/sprite_draw_arbiter.sv
// sprite_draw_arbiter: shares the VGA write port among sprite requesters, scanning 4x4 sprites
//   clk, reset                 clock and synchronous active-high reset
//   req/req_x/req_y/req_colour/req_erase  packed per-requester sprite requests
//   grant, done, busy          handshake back to requesters
//   vga_x/vga_y/vga_colour/vga_plot       registered pixel stream to the adapter
//   SPRITE_DRAW_CLIP_EN        suppresses plots outside the 160x120 screen
module sprite_draw_arbiter import vga_draw_pkg::*; #(
  parameter int N_REQ = 3,
  parameter int X_W = 8,
  parameter int Y_W = 7,
  parameter int C_W = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*X_W-1:0] req_x,
  input  logic [N_REQ*Y_W-1:0] req_y,
  input  logic [N_REQ*C_W-1:0] req_colour,
  input  logic [N_REQ-1:0]   req_erase,
  output logic [N_REQ-1:0]   grant,
  output logic [N_REQ-1:0]   done,
  output logic               busy,
  output logic [X_W-1:0]     vga_x,
  output logic [Y_W-1:0]     vga_y,
  output logic [C_W-1:0]     vga_colour,
  output logic               vga_plot
);
  localparam int LG = $clog2(N_REQ);
`ifdef SPRITE_DRAW_CLIP_EN
  localparam int CLIP = 1;
`else
  localparam int CLIP = 0;
`endif
  // one extra sum bit when clipping so wrapped coordinates land off-screen
  localparam int XS = X_W + CLIP;
  localparam int YS = Y_W + CLIP;
  state_t state, state_n;
  logic [PIX_CNT_W-1:0] count, count_n;
  logic [X_W-1:0] bx, bx_n;
  logic [Y_W-1:0] by, by_n;
  logic [C_W-1:0] col, col_n;
  logic [N_REQ-1:0] pick;
  logic valid;
  logic [LG-1:0] last_grant, pidx;
  logic [XS-1:0] sx;
  logic [YS-1:0] sy;
  logic on_screen;
  rr_arbiter_n #(.N_REQ(N_REQ)) u_rr (.req(req), .last_grant(last_grant), .pick(pick), .valid(valid));
  assign pidx = LG'(onehot_idx(8'(pick)));
  assign busy = state != IDLE;
  // outputs are registered from next state/count so pixel 0 appears the cycle after the latch
  always_comb begin
    state_n = state == IDLE ? (valid ? DRAW : IDLE) : state == DRAW ? (&count ? DONE : DRAW) : IDLE;
    count_n = state == DRAW ? count + PIX_CNT_W'(1) : '0;
    bx_n = state == IDLE ? req_x[pidx*X_W +: X_W] : bx;
    by_n = state == IDLE ? req_y[pidx*Y_W +: Y_W] : by;
    col_n = state == IDLE ? (req_erase[pidx] ? '0 : req_colour[pidx*C_W +: C_W]) : col;
    sx = XS'(bx_n) + XS'(count_n[1:0]);
    sy = YS'(by_n) + YS'(count_n[3:2]);
  end
`ifdef SPRITE_DRAW_CLIP_EN
  assign on_screen = sx < XS'(SCREEN_W) && sy < YS'(SCREEN_H);
`else
  assign on_screen = 1'b1;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
      bx <= '0;
      by <= '0;
      col <= '0;
      last_grant <= LG'(N_REQ - 1);
      grant <= '0;
      done <= '0;
      vga_plot <= 1'b0;
      vga_x <= '0;
      vga_y <= '0;
      vga_colour <= '0;
    end else begin
      state <= state_n;
      count <= count_n;
      bx <= bx_n;
      by <= by_n;
      col <= col_n;
      grant <= state_n == DRAW ? (state == IDLE ? pick : grant) : '0;
      done <= state_n == DONE ? grant : '0;
      if (state_n == DONE) last_grant <= LG'(onehot_idx(8'(grant)));
      vga_plot <= state_n == DRAW && on_screen;
      vga_x <= sx[X_W-1:0];
      vga_y <= sy[Y_W-1:0];
      vga_colour <= col_n;
    end
  end
endmodule
